data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL provide parameter DEPTH_WORDS, default 1024, meaning number of 32-bit words in the storage array.
REQ-002 SHALL provide parameter RD_LAT, default 1, meaning load wait cycles between accept and response (legal 1..7).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  responder can accept.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-009 SHALL have port req_unsigned  input  1  zero-extend load data when 1.
REQ-010 SHALL have port req_addr  input  32  byte address.
REQ-011 SHALL have port req_wdata  input  32  right-justified store data.
REQ-012 SHALL have port rsp_valid  output  1  one-cycle response strobe.
REQ-013 SHALL have port rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-014 SHALL have port rsp_err  output  1  request rejected, qualified by rsp_valid.

Function
REQ-015 SHALL implement FSM IDLE, RD_WAIT, RMW_RD, RMW_WR, RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 SHALL accept on req_valid & req_ready, register all request fields, and ignore inputs until the return to IDLE.
REQ-017 Load: IDLE -> RD_WAIT for RD_LAT cycles -> RESP; rsp_valid SHALL assert RD_LAT+1 cycles after accept.
REQ-018 Store: IDLE -> RMW_RD (read word) -> RMW_WR (merge selected lanes, write) -> RESP; rsp_valid SHALL assert 3 cycles after accept.
REQ-019 Lanes SHALL be selected by addr[1:0]; byte lane n = bits 8n+7:8n, half lane 0/1 = bits 15:0 / 31:16.
REQ-020 Loads SHALL sign-extend from the lane MSB unless req_unsigned; req_unsigned SHALL be ignored for word loads.
REQ-021 Store merge SHALL leave non-selected bytes unchanged.
REQ-022 RESP SHALL last one cycle and return to IDLE; the earliest next accept is the cycle after RESP.
REQ-023 req_size 11 or addr >= 4*DEPTH_WORDS SHALL give rsp_err 1, rsp_rdata 0, no write, same latency.

Reset
REQ-024 On rst low: state IDLE, req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0, independent of clk.
REQ-025 Reset mid-operation SHALL abort with no array write and no response; array contents SHALL NOT be reset.

Configuration
REQ-026 Macro DMEM_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 SHALL give rsp_err 1, rsp_rdata 0, no write, normal latency.
REQ-027 Macro undefined: misaligned low address bits SHALL be forced to 0 and the access completed with rsp_err 0.

Structure
REQ-028 Package dmem_pkg SHALL hold the size encodings, the FSM state typedef and the RD_LAT bounds.
REQ-029 Sub-module dmem_lane_unit SHALL hold the combinational lane extract/extend and store-merge logic.

Verification
REQ-030 Word 0x100 = 0x8899AABB; lb at 0x101 -> rsp_rdata 0xFFFFFFAA at cycle RD_LAT+1; lbu at 0x101 -> 0x000000AA.
REQ-031 sh 0x1234 to 0x102 over 0x8899AABB -> lw at 0x100 returns 0x1234AABB; store rsp_valid at cycle 3.
REQ-032 lw at 0x103: macro defined -> rsp_err 1, rdata 0; undefined -> rsp_err 0, data of word 0x100.
REQ-033 sw to 4*DEPTH_WORDS -> rsp_err 1; that word index mod DEPTH_WORDS is unchanged on readback.
REQ-034 Assert rst low during RMW_WR of sw 0xDEADBEEF to 0x10 -> no rsp_valid; word 0x10 keeps its old value; req_ready 1.
REQ-035 req_valid held high for two back-to-back loads -> second accepted exactly the cycle after the first RESP.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings for the data memory responder: access sizes, FSM states,
// load-latency bounds and the alignment helpers used by the request decoder.
package dmem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RMW_RD,
    ST_RMW_WR,
    ST_RESP
  } state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 7;

  function automatic int clamp_rd_lat(input int lat);
    if (lat < RD_LAT_MIN) return RD_LAT_MIN;
    if (lat > RD_LAT_MAX) return RD_LAT_MAX;
    return lat;
  endfunction

  function automatic logic misaligned(input size_e size, input logic [1:0] offset);
    case (size)
      SIZE_HALF: return offset[0];
      SIZE_WORD: return |offset;
      default:   return 1'b0;
    endcase
  endfunction

  // Low address bits that cannot address a lane of this size are dropped.
  function automatic logic [1:0] align_offset(input size_e size, input logic [1:0] offset);
    case (size)
      SIZE_HALF: return {offset[1], 1'b0};
      SIZE_WORD: return 2'b00;
      default:   return offset;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Combinational lane logic: extracts and sign/zero-extends load data from a
// 32-bit word, and merges right-justified store data into the selected lanes.
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  size_e       size,
  input  logic        zero_ext,
  input  logic [1:0]  offset,
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [3:0]  byte_en;
  logic [31:0] wdata_rep;

  assign lane_byte = rd_word[{offset, 3'b000} +: 8];
  assign lane_half = offset[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    load_data = '0;
    byte_en   = 4'b0000;
    wdata_rep = '0;
    case (size)
      SIZE_BYTE: begin
        load_data = {{24{lane_byte[7] & ~zero_ext}}, lane_byte};
        byte_en   = 4'b0001 << offset;
        wdata_rep = {4{wdata[7:0]}};
      end
      SIZE_HALF: begin
        load_data = {{16{lane_half[15] & ~zero_ext}}, lane_half};
        byte_en   = offset[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
      end
      SIZE_WORD: begin
        load_data = rd_word;
        byte_en   = 4'b1111;
        wdata_rep = wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    merged_word = rd_word;
    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) merged_word[8*i +: 8] = wdata_rep[8*i +: 8];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Single-port data memory responder with byte/half/word loads and
// read-modify-write stores. Define DMEM_MISALIGN_TRAP_EN to reject misaligned
// half/word accesses; otherwise the offending low address bits are ignored.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int RD_LAT      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          LAT        = clamp_rd_lat(RD_LAT);
  localparam int          IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
  localparam logic [2:0]  WAIT_INIT  = 3'(LAT - 1);

  logic [31:0] mem [DEPTH_WORDS];

  state_e      state;
  size_e       size_in;
  size_e       size_q;
  logic        we_q;
  logic        zero_ext_q;
  logic        err_q;
  logic [1:0]  off_q;
  logic [IDX_W-1:0] idx_in;
  logic [IDX_W-1:0] idx_q;
  logic [31:0] wdata_q;
  logic [31:0] rd_word;
  logic [31:0] wr_word;
  logic [31:0] load_data;
  logic [31:0] merged_word;
  logic [2:0]  wait_cnt;
  logic        accept;
  logic        misalign_err;
  logic        req_err;

  assign size_in = size_e'(req_size);
  assign idx_in  = req_addr[IDX_W+1:2];
  assign accept  = req_valid & req_ready;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign_err = misaligned(size_in, req_addr[1:0]);
`else
  assign misalign_err = 1'b0;
`endif

  assign req_err = (size_in == SIZE_RSVD) | ({1'b0, req_addr} >= ADDR_LIMIT) | misalign_err;

  dmem_lane_unit u_lane (
    .size        (size_q),
    .zero_ext    (zero_ext_q),
    .offset      (off_q),
    .rd_word     (rd_word),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  // The array read is launched on the accept edge, so rd_word is stable from
  // the first RD_WAIT / RMW_RD cycle onward.
  // NOTE: the storage array and its read register have no reset; only control state is reset.
  always_ff @(posedge clk) begin
    if (state == ST_RMW_WR && !err_q) mem[idx_q] <= wr_word;
    if (state == ST_IDLE) rd_word <= mem[idx_in];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      we_q       <= 1'b0;
      size_q     <= SIZE_BYTE;
      zero_ext_q <= 1'b0;
      off_q      <= 2'b00;
      idx_q      <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      wait_cnt   <= '0;
      wr_word    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            we_q       <= req_we;
            size_q     <= size_in;
            zero_ext_q <= req_unsigned;
            off_q      <= align_offset(size_in, req_addr[1:0]);
            idx_q      <= idx_in;
            wdata_q    <= req_wdata;
            err_q      <= req_err;
            wait_cnt   <= WAIT_INIT;
            req_ready  <= 1'b0;
            state      <= req_we ? ST_RMW_RD : ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (wait_cnt == 3'd0) begin
            rsp_valid <= 1'b1;
            rsp_err   <= err_q;
            rsp_rdata <= err_q ? 32'h0 : load_data;
            state     <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        ST_RMW_RD: begin
          wr_word <= merged_word;
          state   <= ST_RMW_WR;
        end
        ST_RMW_WR: begin
          rsp_valid <= 1'b1;
          rsp_err   <= err_q;
          rsp_rdata <= '0;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a vector table of loads/stores with
// hand-computed results, plus reset and back-to-back handshake sequences.
module tb_data_mem_responder;

  localparam int RD_LAT      = 3;
  localparam int DEPTH_WORDS = 1024;
  localparam int LD          = RD_LAT + 1;
  localparam int ST          = 3;

  localparam logic [1:0] SB = 2'b00;
  localparam logic [1:0] SH = 2'b01;
  localparam logic [1:0] SW = 2'b10;
  localparam logic [1:0] SR = 2'b11;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  data_mem_responder #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .RD_LAT      (RD_LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] rdata, input logic err, input int lat);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.err = err; v.lat = lat;
    vecs.push_back(v);
  endtask

  task automatic wait_ready();
    @(negedge clk);
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
  endtask

  // Issues one request and returns the response and cycles from accept to rsp_valid (0 = none).
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
    wait_ready();
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0; rdata = '0; err = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (rsp_valid) begin
        lat = i; rdata = rsp_rdata; err = rsp_err;
        break;
      end
      if (i == 1) check("busy_ready", {31'b0, req_ready}, 32'h0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lt;
    int          t1, t2, hits;
    logic [31:0] d1, d2;
    logic        rdy_after, rdy_next, val_after;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = SW;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    #1 rst = 1'b0;
    #1;
    check("reset_ready", {31'b0, req_ready}, 32'h1);
    check("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    check("reset_rsp_err", {31'b0, rsp_err}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    add(1, SW, 0, 32'h100, 32'h8899AABB, 32'h0,        0, ST);
    add(0, SW, 0, 32'h100, 32'h0,        32'h8899AABB, 0, LD);
    add(0, SB, 0, 32'h101, 32'h0,        32'hFFFFFFAA, 0, LD);
    add(0, SB, 1, 32'h101, 32'h0,        32'h000000AA, 0, LD);
    add(0, SB, 0, 32'h100, 32'h0,        32'hFFFFFFBB, 0, LD);
    add(0, SB, 0, 32'h103, 32'h0,        32'hFFFFFF88, 0, LD);
    add(0, SB, 1, 32'h102, 32'h0,        32'h00000099, 0, LD);
    add(0, SH, 0, 32'h100, 32'h0,        32'hFFFFAABB, 0, LD);
    add(0, SH, 1, 32'h102, 32'h0,        32'h00008899, 0, LD);
    add(0, SH, 0, 32'h102, 32'h0,        32'hFFFF8899, 0, LD);
    add(1, SH, 0, 32'h102, 32'hABCD1234, 32'h0,        0, ST);
    add(0, SW, 0, 32'h100, 32'h0,        32'h1234AABB, 0, LD);
    add(1, SB, 0, 32'h100, 32'hFFFFFF7E, 32'h0,        0, ST);
    add(0, SW, 0, 32'h100, 32'h0,        32'h1234AA7E, 0, LD);
    add(0, SB, 0, 32'h100, 32'h0,        32'h0000007E, 0, LD);
    add(0, SW, 1, 32'h100, 32'h0,        32'h1234AA7E, 0, LD);
    add(1, SB, 0, 32'h102, 32'h00000080, 32'h0,        0, ST);
    add(0, SW, 0, 32'h100, 32'h0,        32'h1280AA7E, 0, LD);
    add(0, SB, 0, 32'h102, 32'h0,        32'hFFFFFF80, 0, LD);
    add(0, SH, 0, 32'h102, 32'h0,        32'h00001280, 0, LD);
    add(0, SR, 0, 32'h100, 32'h0,        32'h0,        1, LD);
    add(1, SR, 0, 32'h100, 32'h0,        32'h0,        1, ST);
    add(0, SW, 0, 32'h100, 32'h0,        32'h1280AA7E, 0, LD);
    add(1, SW, 0, 32'h104, 32'hCAFEF00D, 32'h0,        0, ST);
    add(1, SB, 0, 32'h107, 32'h00000001, 32'h0,        0, ST);
    add(1, SH, 0, 32'h104, 32'h00005555, 32'h0,        0, ST);
    add(0, SW, 0, 32'h104, 32'h0,        32'h01FE5555, 0, LD);
    add(1, SW, 0, 32'h000, 32'h11223344, 32'h0,        0, ST);
    add(1, SW, 0, 32'h1000, 32'hDEADBEEF, 32'h0,       1, ST);
    add(0, SW, 0, 32'h000, 32'h0,        32'h11223344, 0, LD);
    add(0, SW, 0, 32'h1000, 32'h0,       32'h0,        1, LD);
    add(1, SW, 0, 32'hFFC, 32'hA5A5A5A5, 32'h0,        0, ST);
    add(0, SB, 1, 32'hFFF, 32'h0,        32'h000000A5, 0, LD);
    add(0, SW, 0, 32'hFFC, 32'h0,        32'hA5A5A5A5, 0, LD);
    add(0, SW, 0, 32'hFFFFFFFC, 32'h0,   32'h0,        1, LD);
    add(1, SW, 0, 32'h010, 32'h01020304, 32'h0,        0, ST);
`ifdef DMEM_MISALIGN_TRAP_EN
    add(0, SW, 0, 32'h103, 32'h0,        32'h0,        1, LD);
    add(0, SH, 0, 32'h101, 32'h0,        32'h0,        1, LD);
    add(1, SW, 0, 32'h106, 32'h77777777, 32'h0,        1, ST);
    add(0, SW, 0, 32'h104, 32'h0,        32'h01FE5555, 0, LD);
`else
    add(0, SW, 0, 32'h103, 32'h0,        32'h1280AA7E, 0, LD);
    add(0, SH, 0, 32'h101, 32'h0,        32'hFFFFAA7E, 0, LD);
    add(1, SW, 0, 32'h106, 32'h77777777, 32'h0,        0, ST);
    add(0, SW, 0, 32'h104, 32'h0,        32'h77777777, 0, LD);
`endif

    foreach (vecs[i]) begin
      do_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, rd, er, lt);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
      check($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, vecs[i].err});
      check($sformatf("vec%0d_latency", i), lt, vecs[i].lat);
    end

    // Back-to-back loads with req_valid held; address changes while busy must be ignored.
    t1 = 0; t2 = 0; d1 = '0; d2 = '0; rdy_after = 1'b0; rdy_next = 1'b1; val_after = 1'b1;
    wait_ready();
    req_valid = 1'b1; req_we = 1'b0; req_size = SW; req_unsigned = 1'b0; req_addr = 32'h100;
    @(posedge clk);
    #1;
    req_addr = 32'h000;
    for (int t = 1; t <= 16; t++) begin
      if (rsp_valid) begin
        if (t1 == 0) begin t1 = t; d1 = rsp_rdata; end
        else if (t2 == 0) begin t2 = t; d2 = rsp_rdata; end
      end
      if (t1 != 0 && t == t1 + 1) begin rdy_after = req_ready; val_after = rsp_valid; end
      if (t1 != 0 && t == t1 + 2) begin rdy_next = req_ready; req_valid = 1'b0; end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    check("b2b_first_latency", t1, LD);
    check("b2b_first_rdata", d1, 32'h1280AA7E);
    check("b2b_strobe_one_cycle", {31'b0, val_after}, 32'h0);
    check("b2b_ready_after_resp", {31'b0, rdy_after}, 32'h1);
    check("b2b_second_accepted", {31'b0, rdy_next}, 32'h0);
    check("b2b_second_time", t2, t1 + 1 + LD);
    check("b2b_second_rdata", d2, 32'h11223344);

    // Asynchronous reset while a load response is on the outputs.
    wait_ready();
    req_valid = 1'b1; req_we = 1'b0; req_size = SW; req_addr = 32'h100;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int i = 0; i < 20 && !rsp_valid; i++) begin
      @(posedge clk);
      #1;
    end
    check("resp_pre_reset_rdata", rsp_rdata, 32'h1280AA7E);
    rst = 1'b0;
    #1;
    check("async_rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("async_rst_rsp_rdata", rsp_rdata, 32'h0);
    check("async_rst_ready", {31'b0, req_ready}, 32'h1);
    @(negedge clk);
    rst = 1'b1;

    // Reset during RMW_WR of a store: no write, no response.
    wait_ready();
    req_valid = 1'b1; req_we = 1'b1; req_size = SW; req_addr = 32'h010; req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rmw_rst_ready", {31'b0, req_ready}, 32'h1);
    check("rmw_rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) hits++;
    end
    check("rmw_rst_no_response", hits, 0);
    do_req(0, SW, 0, 32'h010, 32'h0, rd, er, lt);
    check("rmw_rst_word_kept", rd, 32'h01020304);
    check("rmw_rst_readback_err", {31'b0, er}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
